// File: rtl/fir_requant_decim_if.sv
// Stream bundle around fir_requant_decim: FIR sample input and valid/ready output.
// A word moves on dout exactly when dout_valid && dout_ready at a rising edge;
// din is taken whenever din_valid is high, with no backpressure toward the FIR.
interface fir_requant_decim_if #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 16
);
    logic [DIN_W-1:0]  din;
    logic              din_valid;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output din, din_valid, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/fir_requant_decim.sv
// Decimate, round (half-up, or half-to-even with REQUANT_CONVERGENT_EN) and saturate
// the FIR accumulator to Q1.15, then buffer in a drop-on-full FIFO.
module fir_requant_decim #(
    parameter int DIN_W      = 32,
    parameter int DOUT_W     = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_requant_decim_if.slave     s,
    input  logic                   clr_status,
    output logic                   sat_pulse,
    output logic                   ovf_sticky,
    output logic [7:0]             drop_cnt
);
    localparam int RW   = DIN_W + 1;
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);

    logic [PH_W-1:0]        phase_q, phase_d;
    logic signed [RW-1:0]   r_q, r_d;
    logic                   v1_q, v1_d;
    logic [DOUT_W-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             drop_q, drop_d;

    logic                   keep;
    logic signed [RW-1:0]   din_ext, sum_s, rounded;
    logic                   tie;
    logic [RW-DOUT_W:0]     hi_bits;
    logic                   sat_hi, sat_lo;
    logic [DOUT_W-1:0]      wr_word;
    logic                   empty, full, pop, wr_ok, drop;

    assign keep    = s.din_valid && (phase_q == '0);
    assign din_ext = $signed({s.din[DIN_W-1], s.din});
    assign sum_s   = din_ext + $signed(RW'(HALF));
    assign rounded = sum_s >>> SHIFT;
    assign tie     = (s.din[SHIFT-1:0] == HALF);

    // Clamp when the bits above the output sign bit are not a pure sign extension.
    assign hi_bits = r_q[RW-1:DOUT_W-1];
    assign sat_hi  = !r_q[RW-1] && (|hi_bits);
    assign sat_lo  = r_q[RW-1] && !(&hi_bits);
    assign wr_word = sat_hi ? {1'b0, {(DOUT_W-1){1'b1}}} :
                     sat_lo ? {1'b1, {(DOUT_W-1){1'b0}}} :
                              r_q[DOUT_W-1:0];

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign pop   = !empty && s.dout_ready;
    assign wr_ok = v1_q && (!full || pop);
    assign drop  = v1_q && full && !pop;

    assign s.dout_valid = !empty;
    assign s.dout       = empty ? '0 : mem_q[rptr_q];
    assign sat_pulse    = sat_q;
    assign ovf_sticky   = ovf_q;
    assign drop_cnt     = drop_q;

    always_comb begin
        phase_d = phase_q;
        if (s.din_valid) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end

        v1_d = keep;
        r_d  = r_q;
        if (keep) begin
            r_d = rounded;
`ifdef REQUANT_CONVERGENT_EN
            // Half-up landed on an odd value for an exact tie: step back to the even neighbour.
            if (tie && rounded[0]) begin
                r_d = rounded - RW'(1);
            end
`endif
        end

        wptr_d = wr_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop   ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!wr_ok && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end

        sat_d  = wr_ok && (sat_hi || sat_lo);
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_status) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            r_q     <= '0;
            v1_q    <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            phase_q <= phase_d;
            r_q     <= r_d;
            v1_q    <= v1_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wr_word;
        end
    end

`ifndef REQUANT_CONVERGENT_EN
    logic unused_tie;
    assign unused_tie = tie;
`endif
endmodule

// File: tb/tb_fir_requant_decim.sv
// Directed bench for fir_requant_decim: one DECIM=1 instance for rounding, saturation,
// overflow and reset; one DECIM=3 instance for decimation.
module tb_fir_requant_decim;
    logic clk = 1'b0;
    logic rst;
    logic clr_status;
    logic sat_a, ovf_a, sat_b, ovf_b;
    logic [7:0] drop_a, drop_b;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    fir_requant_decim_if #(.DIN_W(32), .DOUT_W(16)) a_if ();
    fir_requant_decim_if #(.DIN_W(32), .DOUT_W(16)) b_if ();

    fir_requant_decim #(.DECIM(1)) u_dut_a (
        .clk(clk), .rst(rst), .s(a_if.slave), .clr_status(clr_status),
        .sat_pulse(sat_a), .ovf_sticky(ovf_a), .drop_cnt(drop_a)
    );

    fir_requant_decim #(.DECIM(3)) u_dut_b (
        .clk(clk), .rst(rst), .s(b_if.slave), .clr_status(clr_status),
        .sat_pulse(sat_b), .ovf_sticky(ovf_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One kept sample into an empty FIFO with the consumer ready.
    task automatic round_vec(input string tag, input logic [31:0] d,
                             input logic [15:0] e, input logic s);
        a_if.din       = d;
        a_if.din_valid = 1'b1;
        tick();
        check({tag, "_lat"}, 32'(a_if.dout_valid), 32'd0);
        a_if.din_valid = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(a_if.dout_valid), 32'd1);
        check(tag, 32'(a_if.dout), 32'(e));
        check({tag, "_sat"}, 32'(sat_a), 32'(s));
        tick();
    endtask

    task automatic push_a(input logic [31:0] n);
        a_if.din       = n << 15;
        a_if.din_valid = 1'b1;
        tick();
        a_if.din_valid = 1'b0;
    endtask

    task automatic collect_b();
        if (b_if.dout_valid) got_q.push_back(b_if.dout);
    endtask

    initial begin
        rst = 1'b1;
        clr_status = 1'b0;
        a_if.din = '0; a_if.din_valid = 1'b0; a_if.dout_ready = 1'b1;
        b_if.din = '0; b_if.din_valid = 1'b0; b_if.dout_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(a_if.dout_valid), 32'd0);
        check("rst_dout", 32'(a_if.dout), 32'd0);
        check("rst_sat", 32'(sat_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_drop", 32'(drop_a), 32'd0);
        check("rst_b_valid", 32'(b_if.dout_valid), 32'd0);

`ifdef REQUANT_CONVERGENT_EN
        round_vec("rnd_half_pos", 32'h0000_4000, 16'h0000, 1'b0);
`else
        round_vec("rnd_half_pos", 32'h0000_4000, 16'h0001, 1'b0);
`endif
        round_vec("rnd_1p5", 32'h0000_C000, 16'h0002, 1'b0);
        round_vec("rnd_half_neg", 32'hFFFF_C000, 16'h0000, 1'b0);
        round_vec("sat_pos", 32'h4000_0000, 16'h7FFF, 1'b1);
        round_vec("sat_neg", 32'h8000_0000, 16'h8000, 1'b1);
        round_vec("near_max", 32'h3FFF_BFFF, 16'h7FFF, 1'b0);

        // Decimation by 3 with a din_valid gap after n=3.
        exp_q = '{16'd0, 16'd3, 16'd6};
        for (int n = 0; n < 9; n++) begin
            if (n == 4) begin
                b_if.din_valid = 1'b0;
                tick();
                collect_b();
            end
            b_if.din       = 32'(n) << 15;
            b_if.din_valid = 1'b1;
            tick();
            collect_b();
        end
        b_if.din_valid = 1'b0;
        repeat (4) begin
            tick();
            collect_b();
        end
        check("dec_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("dec_out%0d", i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        end

        // Overflow: six samples into a stalled four-entry FIFO.
        a_if.dout_ready = 1'b0;
        for (int n = 1; n <= 6; n++) push_a(32'(n));
        tick();
        tick();
        check("ovf_sticky", 32'(ovf_a), 32'd1);
        check("ovf_drop", 32'(drop_a), 32'd2);
        check("ovf_sat_quiet", 32'(sat_a), 32'd0);
        a_if.dout_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            check($sformatf("ovf_pop%0d", n), 32'(a_if.dout), 32'(n));
            tick();
        end
        check("ovf_empty", 32'(a_if.dout_valid), 32'd0);
        check("ovf_held", 32'(ovf_a), 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("clr_ovf", 32'(ovf_a), 32'd0);
        check("clr_drop", 32'(drop_a), 32'd0);

        // Full FIFO: a write lands on the same edge as a pop.
        a_if.dout_ready = 1'b0;
        for (int n = 10; n <= 13; n++) push_a(32'(n));
        tick();
        a_if.din       = 32'd14 << 15;
        a_if.din_valid = 1'b1;
        tick();
        a_if.din_valid  = 1'b0;
        a_if.dout_ready = 1'b1;
        tick();
        a_if.dout_ready = 1'b0;
        check("full_pop_drop", 32'(drop_a), 32'd0);
        check("full_pop_ovf", 32'(ovf_a), 32'd0);
        a_if.dout_ready = 1'b1;
        for (int n = 11; n <= 14; n++) begin
            check($sformatf("full_pop%0d", n), 32'(a_if.dout), 32'(n));
            tick();
        end
        check("full_pop_empty", 32'(a_if.dout_valid), 32'd0);

        // Reset with buffered data and a nonzero drop count.
        a_if.dout_ready = 1'b0;
        for (int n = 20; n <= 24; n++) push_a(32'(n));
        tick();
        check("pre_rst_drop", 32'(drop_a), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(a_if.dout_valid), 32'd0);
        check("mid_rst_drop", 32'(drop_a), 32'd0);
        check("mid_rst_ovf", 32'(ovf_a), 32'd0);
        a_if.din       = 32'd30 << 15;
        a_if.din_valid = 1'b1;
        tick();
        a_if.din_valid = 1'b0;
        check("post_rst_lat", 32'(a_if.dout_valid), 32'd0);
        tick();
        check("post_rst_valid", 32'(a_if.dout_valid), 32'd1);
        check("post_rst_dout", 32'(a_if.dout), 32'd30);
        a_if.dout_ready = 1'b1;
        tick();
        check("post_rst_empty", 32'(a_if.dout_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
